// File: rtl/mmio_timer_pkg.sv
// Shared definitions for the memory-mapped timer: register offsets,
// CTRL field positions and the helpers that pack/unpack CTRL.
package mmio_timer_pkg;

  localparam logic [1:0] TMR_CTRL    = 2'd0;
  localparam logic [1:0] TMR_COUNT   = 2'd1;
  localparam logic [1:0] TMR_COMPARE = 2'd2;
  localparam logic [1:0] TMR_STATUS  = 2'd3;

  localparam int EN      = 0;
  localparam int AR      = 1;
  localparam int IE      = 2;
  localparam int DIV_LSB = 8;
  localparam int DIV_MSB = 15;

  typedef struct packed {
    logic [7:0] div;
    logic       ie;
    logic       ar;
    logic       en;
  } ctrl_t;

  function automatic ctrl_t ctrl_unpack(input logic [31:0] word);
    ctrl_t c;
    c.en  = word[EN];
    c.ar  = word[AR];
    c.ie  = word[IE];
    c.div = word[DIV_MSB:DIV_LSB];
    return c;
  endfunction

  function automatic logic [31:0] ctrl_pack(input ctrl_t c);
    logic [31:0] word;
    word                   = '0;
    word[EN]               = c.en;
    word[AR]               = c.ar;
    word[IE]               = c.ie;
    word[DIV_MSB:DIV_LSB]  = c.div;
    return word;
  endfunction

endpackage

// File: rtl/mmio_timer_prescaler.sv
// Divide-by-(div+1) prescaler: emits a one-cycle tick each time pcnt
// reaches div while enabled.
module prescaler
  import mmio_timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] div,
  input  logic       clr,
  output logic       tick
);

  logic [7:0] pcnt_reg;

  assign tick = en & (pcnt_reg == div);

  always_ff @(posedge clk) begin
    if (reset || !en || clr) begin
      pcnt_reg <= 8'd0;
    end else if (tick) begin
      pcnt_reg <= 8'd0;
    end else begin
      pcnt_reg <= pcnt_reg + 8'd1;
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped 32-bit timer: address decode, register file, counter with
// compare/auto-reload, interrupt and a zero-latency read mux.
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter logic [31:0] BASE = 32'h0000_4000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] dIn,
  output logic [31:0] dOut,
  output logic        hit,
  output logic        irq
);

  ctrl_t       ctrl_reg;
  logic [31:0] count_reg;
  logic [31:0] compare_reg;
  logic        match_reg;

  logic [1:0]  sel;
  logic        wr;
  logic        wr_ctrl;
  logic        wr_count;
  logic        wr_compare;
  logic        wr_status;
  logic        div_change;
  logic        pcnt_clr;
  logic        tick;
  logic        at_compare;
  ctrl_t       ctrl_in;
  logic        unused_addr_bits;

  // Byte lanes inside a word are not decoded.
  assign unused_addr_bits = ^addr[1:0];

  assign hit        = (addr[31:4] == BASE[31:4]);
  assign sel        = addr[3:2];
  assign wr         = we & hit;
  assign wr_ctrl    = wr & (sel == TMR_CTRL);
  assign wr_count   = wr & (sel == TMR_COUNT);
  assign wr_compare = wr & (sel == TMR_COMPARE);
  assign wr_status  = wr & (sel == TMR_STATUS);
  assign ctrl_in    = ctrl_unpack(dIn);
  assign div_change = wr_ctrl & (ctrl_in.div != ctrl_reg.div);
  assign pcnt_clr   = wr_count | div_change;
  assign at_compare = (count_reg == compare_reg);
  assign irq        = match_reg & ctrl_reg.ie;

  prescaler u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (ctrl_reg.en),
    .div   (ctrl_reg.div),
    .clr   (pcnt_clr),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_reg    <= '0;
      count_reg   <= 32'd0;
      compare_reg <= 32'd0;
      match_reg   <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_reg <= ctrl_in;
      end
      if (wr_compare) begin
        compare_reg <= dIn;
      end
      // A CPU write to COUNT beats a coincident tick.
      if (wr_count) begin
        count_reg <= dIn;
      end else if (tick) begin
        if (at_compare && ctrl_reg.ar) begin
          count_reg <= 32'd0;
        end else begin
          count_reg <= count_reg + 32'd1;
        end
      end
      // Setting a match takes priority over a simultaneous clear.
      if (tick && at_compare) begin
        match_reg <= 1'b1;
      end else if (wr_status && dIn[0]) begin
        match_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    dOut = 32'd0;
    if (hit) begin
      case (sel)
        TMR_CTRL:    dOut = ctrl_pack(ctrl_reg);
        TMR_COUNT:   dOut = count_reg;
        TMR_COMPARE: dOut = compare_reg;
        TMR_STATUS:  dOut = {31'd0, match_reg};
        default:     dOut = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// Directed self-checking bench for mmio_timer: reset, prescale/wrap,
// auto-reload with irq, write collisions, masking/decode, mid-count reset.
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'h0000_4000;
  localparam logic [31:0] A_CTRL = BASE + 32'h0;
  localparam logic [31:0] A_CNT  = BASE + 32'h4;
  localparam logic [31:0] A_CMP  = BASE + 32'h8;
  localparam logic [31:0] A_STAT = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = 32'd0;
  logic        we = 1'b0;
  logic [31:0] dIn = 32'd0;
  logic [31:0] dOut;
  logic        hit;
  logic        irq;

  int checks = 0;
  int errors = 0;

  mmio_timer #(.BASE(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .dIn   (dIn),
    .dOut  (dOut),
    .hit   (hit),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
    $display("check %-14s observed %h expected %h", tag, got, exp);
  endtask

  task automatic edges(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    dIn  = d;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we   = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    we   = 1'b0;
    #1;
    chk(tag, dOut, exp);
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    #1;
    chk(tag, {31'd0, irq}, {31'd0, exp});
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    edges(1);
    reset = 1'b0;
    rd("rst_ctrl", A_CTRL, 32'd0);
    chk("rst_hit", {31'd0, hit}, 32'd1);
    rd("rst_count", A_CNT, 32'd0);
    rd("rst_cmp", A_CMP, 32'd0);
    rd("rst_stat", A_STAT, 32'd0);
    chk_irq("rst_irq", 1'b0);
    rd("miss_dout", 32'h0000_5000, 32'd0);
    chk("miss_hit", {31'd0, hit}, 32'd0);

    // Prescale by 3 and wrap through zero
    wr(A_CNT, 32'hFFFF_FFFE);
    wr(A_CMP, 32'h0000_0010);
    wr(A_CTRL, 32'h0000_0201);
    edges(2);
    rd("psc_2", A_CNT, 32'hFFFF_FFFE);
    edges(1);
    rd("psc_3", A_CNT, 32'hFFFF_FFFF);
    edges(3);
    rd("psc_wrap", A_CNT, 32'd0);
    rd("psc_nomatch", A_STAT, 32'd0);
    wr(A_CTRL, 32'd0);
    rd("psc_frozen", A_CNT, 32'd0);

    // Auto-reload with interrupt, div = 0
    wr(A_CMP, 32'd3);
    wr(A_CTRL, 32'h0000_0007);
    edges(1);
    rd("ar_1", A_CNT, 32'd1);
    edges(1);
    rd("ar_2", A_CNT, 32'd2);
    edges(1);
    rd("ar_3", A_CNT, 32'd3);
    chk_irq("ar_irq_lo", 1'b0);
    edges(1);
    rd("ar_reload", A_CNT, 32'd0);
    chk_irq("ar_irq_hi", 1'b1);
    rd("ar_match", A_STAT, 32'd1);
    edges(1);
    rd("ar_again1", A_CNT, 32'd1);
    wr(A_STAT, 32'd1);
    chk_irq("w1c_irq", 1'b0);
    rd("w1c_count", A_CNT, 32'd2);

    // STATUS clear coinciding with a match set: set wins
    edges(1);
    rd("col_pre", A_CNT, 32'd3);
    wr(A_STAT, 32'd1);
    rd("col_match", A_STAT, 32'd1);
    chk_irq("col_irq", 1'b1);

    // COUNT write on a tick edge wins and restarts the prescaler
    wr(A_CTRL, 32'd0);
    wr(A_STAT, 32'd1);
    rd("clr_stat", A_STAT, 32'd0);
    wr(A_CMP, 32'h0000_1000);
    wr(A_CNT, 32'h0000_0010);
    wr(A_CTRL, 32'h0000_0201);
    edges(2);
    wr(A_CNT, 32'h0000_0100);
    rd("cw_win", A_CNT, 32'h0000_0100);
    edges(2);
    rd("cw_hold", A_CNT, 32'h0000_0100);
    edges(1);
    rd("cw_step", A_CNT, 32'h0000_0101);

    // Masking and decode
    wr(A_CTRL, 32'hFFFF_FFFF);
    rd("mask_ctrl", A_CTRL, 32'h0000_FF07);
    wr(A_CTRL, 32'd0);
    wr(A_STAT, 32'hFFFF_FFFF);
    rd("mask_stat", A_STAT, 32'd0);
    wr(BASE + 32'h10, 32'hFFFF_FFFF);
    rd("oob_dout", BASE + 32'h10, 32'd0);
    chk("oob_hit", {31'd0, hit}, 32'd0);
    rd("oob_ctrl", A_CTRL, 32'd0);
    rd("oob_count", A_CNT, 32'h0000_0101);
    rd("oob_cmp", A_CMP, 32'h0000_1000);

    // Reset while counting
    wr(A_CNT, 32'h0000_0055);
    wr(A_CTRL, 32'h0000_0001);
    rd("mid_count", A_CNT, 32'h0000_0055);
    reset = 1'b1;
    edges(1);
    reset = 1'b0;
    rd("mid_ctrl", A_CTRL, 32'd0);
    rd("mid_cnt0", A_CNT, 32'd0);
    rd("mid_cmp", A_CMP, 32'd0);
    rd("mid_stat", A_STAT, 32'd0);
    chk_irq("mid_irq", 1'b0);
    edges(3);
    rd("mid_idle", A_CNT, 32'd0);
    wr(A_CTRL, 32'h0000_0001);
    edges(1);
    rd("mid_restart", A_CNT, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_timer.md
# mmio_timer

Memory-mapped timer peripheral that responds to the CPU's data-memory port (addr, we, dIn, dOut). It decodes a 16-byte address window, serves single-cycle combinational reads and clocked writes, and runs a prescaled 32-bit up-counter with compare-match, auto-reload and an interrupt output. At top level it sits beside the data memory; the top selects `dOut` from this block whenever `hit` is high.

## Interface
- `BASE`, 32'h0000_4000: window base address; bits [3:0] must be zero.
- `clk`  input  1: system clock; all state changes on its rising edge.
- `reset`  input  1: synchronous, active-high; clears all state on a rising edge of `clk`.
- `addr`  input  32: byte address from the CPU ALU output; bits [1:0] ignored.
- `we`  input  1: data write enable from the CPU.
- `dIn`  input  32: write data from the CPU (register B output).
- `dOut`  output  32: read data; 0 when `hit` is low.
- `hit`  output  1: `addr[31:4] == BASE[31:4]`; combinational.
- `irq`  output  1: `STATUS.match & CTRL.ie`.

## Operation
Register map (offset = `addr[3:2]`):
- 0 CTRL: bit0 `en`, bit1 `ar` (auto-reload), bit2 `ie`, bits [15:8] `div`; other bits read 0.
- 1 COUNT: 32-bit counter value; read/write.
- 2 COMPARE: 32-bit match value; read/write.
- 3 STATUS: bit0 `match`; write 1 to clear, write 0 no effect; other bits read 0.

Writes: when `we & hit` at a rising edge, the selected register takes `dIn`, masked to its defined bits. No write occurs when `hit` is low.

Prescaler: 8-bit `pcnt`, active when `en` = 1.
- `tick` = `en & (pcnt == div)`.
- On tick, `pcnt` returns to 0; otherwise it increments. The counter therefore advances every `div`+1 cycles; `div` = 0 gives one step per cycle.
- While `en` = 0, `pcnt` holds at 0.

Counter, on `tick`:
- If COUNT == COMPARE: set `match`. COUNT then goes to 0 if `ar` = 1, otherwise to COUNT+1.
- Else: COUNT goes to COUNT+1, wrapping from 32'hFFFF_FFFF to 0.

Priority and boundary rules:
- `reset` overrides everything.
- A CPU write to COUNT in the same cycle as `tick` wins, and also clears `pcnt` to 0.
- A write to CTRL that changes `div` clears `pcnt`.
- When a STATUS write-1-to-clear coincides with a match set, the set wins, so `match` stays 1.
- Writing COMPARE equal to the current COUNT takes effect on the next tick.
- Clearing `en` freezes COUNT and clears `pcnt`; `match` is retained.

## Timing
- Reset values: CTRL, COUNT, COMPARE, STATUS and `pcnt` are all 0. Therefore `irq` = 0, and `dOut` = 0 unless a read of the window is in progress.
- Reads: zero latency. `dOut` is a combinational function of `addr` and the current register state, matching the data memory's read behaviour for the single-cycle CPU.
- Writes: visible on `dOut` and in behaviour from the cycle after the edge.
- Match: `match` and `irq` rise in the cycle after the tick edge at which COUNT == COMPARE.
- After `en` is written 1 with `div` = N, the first COUNT increment occurs on the (N+1)th rising edge following the write edge.

## Structure
- Shared package holds:
  - register offset constants: `TMR_CTRL` = 0, `TMR_COUNT` = 1, `TMR_COMPARE` = 2, `TMR_STATUS` = 3;
  - CTRL bit-position constants: `EN` = 0, `AR` = 1, `IE` = 2, `DIV_LSB` = 8, `DIV_MSB` = 15.
- One natural sub-module, `prescaler`. Inputs: `clk`, `reset`, `en`, `div`, `clr`. Output: `tick`. It contains the 8-bit `pcnt` and the terminal-count compare.
- Address decode, register file, counter and read mux stay in `mmio_timer`.

## Test plan
- Reset check: assert `reset` for one edge, then read offsets 0x0–0xC at BASE. Every read returns 0, `hit` = 1 and `irq` = 0. Reading 32'h0000_5000 gives `hit` = 0 and `dOut` = 0.
- Prescale and wrap:
  - Write COUNT = 32'hFFFF_FFFE, COMPARE = 32'h10, then CTRL = 32'h0000_0201 (`div` = 2, `en`).
  - Required: COUNT reads 32'hFFFF_FFFF after 3 edges and 0 after 6 edges; `match` stays 0.
- Auto-reload with interrupt:
  - Write COMPARE = 3, then CTRL = 32'h0000_0007 (`div` = 0, `en`, `ar`, `ie`).
  - Required: COUNT follows 1, 2, 3, 0, 1, …; `irq` rises in the cycle after the edge where COUNT was 3.
  - Writing STATUS = 1 clears `irq` on the next cycle.
- Collisions:
  - Write COUNT = 32'h100 on the same edge as a tick: COUNT reads 32'h100, and the next increment comes `div`+1 edges later.
  - STATUS write-1 on a match edge: `match` stays 1.
- Masking and decode:
  - Write 32'hFFFF_FFFF to CTRL, then read it back: 32'h0000_FF07.
  - Write 32'hFFFF_FFFF to STATUS while `match` = 0: `match` stays 0.
  - Write with `we` = 1 at BASE+0x10: no register changes.
- Reset mid-count: `reset` while `en` = 1 and COUNT = 32'h55. All registers and `pcnt` read 0 on the next cycle, and the counter stays idle until `en` is written again.
